// File: rtl/twdl_seq_pkg.sv
// Shared types and constants for the twiddle-descriptor sequencer.
package twdl_seq_pkg;

  localparam int unsigned W_NUM   = 12;
  localparam int unsigned W_QUO   = 20;
  localparam int unsigned DIV_CYC_DEF = W_QUO + 1;

  localparam logic [2:0] FACTOR_MIN = 3'd2;
  localparam logic [2:0] FACTOR_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_RUN
  } seq_state_e;

  typedef struct packed {
    logic             sop;
    logic [W_NUM-1:0] numrtr;
    logic [W_NUM-1:0] demontr;
    logic [W_QUO-1:0] quotient;
    logic [W_NUM-1:0] remainder;
  } twdl_desc_t;

  function automatic logic factor_ok(input logic [2:0] f);
    return (f >= FACTOR_MIN) && (f <= FACTOR_MAX);
  endfunction

endpackage

// File: rtl/seq_div_u20.sv
// Restoring divider of the fixed dividend 2^wQuo by a wNum-bit divisor.
// Latency is DIV_CYC cycles from go to the done pulse.
module seq_div_u20
  import twdl_seq_pkg::*;
#(
  parameter int unsigned wNum    = W_NUM,
  parameter int unsigned wQuo    = W_QUO,
  parameter int unsigned DIV_CYC = DIV_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [wNum-1:0] divisor,
  output logic            done,
  output logic [wQuo-1:0] quo,
  output logic [wNum-1:0] rem
);

  localparam int unsigned CW = $clog2(DIV_CYC + 1);

  logic [wNum-1:0] dvs;
  logic [wNum-1:0] part;
  logic [CW-1:0]   cnt;
  logic [wNum-1:0] dvs_use;
  logic [wNum:0]   trial;
  logic            fits;

  // The go cycle itself performs the iteration for the dividend's only set bit.
  always_comb begin
    dvs_use = go ? divisor : dvs;
    trial   = go ? {{wNum{1'b0}}, 1'b1} : {part, 1'b0};
    fits    = trial >= {1'b0, dvs_use};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs  <= '0;
      part <= '0;
      quo  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        dvs  <= divisor;
        part <= wNum'(fits ? trial - {1'b0, dvs_use} : trial);
        quo  <= {{(wQuo-1){1'b0}}, fits};
        cnt  <= CW'(DIV_CYC - 1);
      end else if (cnt != '0) begin
        part <= wNum'(fits ? trial - {1'b0, dvs_use} : trial);
        quo  <= {quo[wQuo-2:0], fits};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1))
          done <= 1'b1;
      end
    end
  end

  assign rem = part;

endmodule

// File: rtl/twdl_seq_ctrl.sv
// Per-stage twiddle descriptor sequencer: latches stage config, divides 2^wQuo by D,
// then emits one (k, D, q, r) descriptor per butterfly. Optional TWDL_SEQ_STAT_EN adds drop_cnt.
module twdl_seq_ctrl
  import twdl_seq_pkg::*;
#(
  parameter int unsigned wNum    = W_NUM,
  parameter int unsigned wQuo    = W_QUO,
  parameter int unsigned DIV_CYC = DIV_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      cfg_factor,
  input  logic [wNum-1:0] cfg_demontr,
  input  logic [wNum-1:0] cfg_num_per_grp,
  input  logic [wNum-1:0] cfg_num_grps,
  input  logic            cfg_inverse,
  input  logic            bfly_req,
  output logic            ready,
  output logic            busy,
  output logic            cfg_err,
  output logic            done,
  output logic            twdl_val,
  output logic            twdl_sop,
  output logic [wNum-1:0] twdl_numrtr,
  output logic [wNum-1:0] twdl_demontr,
  output logic [wQuo-1:0] twdl_quotient,
  output logic [wNum-1:0] twdl_remainder,
`ifdef TWDL_SEQ_STAT_EN
  output logic [15:0]     drop_cnt,
`endif
  output logic [2:0]      factor,
  output logic            inverse
);

  seq_state_e      st;
  twdl_desc_t      desc;
  logic [wNum-1:0] dem, m_num, g_num;
  logic [wQuo-1:0] step_q, acc_q;
  logic [wNum-1:0] step_r, acc_r;
  logic [wNum-1:0] k, grp;
  logic            first;
  logic            cfg_good, div_go, div_done;
  logic [wQuo-1:0] div_quo;
  logic [wNum-1:0] div_rem;
  logic [wNum:0]   r_sum;
  logic            wrap, grp_last;

  assign cfg_good = factor_ok(cfg_factor) && (cfg_demontr >= wNum'(2)) &&
                    (cfg_num_per_grp != '0) && (cfg_num_grps != '0) &&
                    (cfg_num_per_grp <= cfg_demontr);
  assign div_go   = (st == ST_IDLE) && start && cfg_good;
  assign ready    = (st == ST_RUN);
  assign busy     = (st != ST_IDLE);
  assign r_sum    = {1'b0, acc_r} + {1'b0, step_r};
  assign wrap     = (k == m_num - wNum'(1));
  assign grp_last = (grp == g_num - wNum'(1));

  seq_div_u20 #(.wNum(wNum), .wQuo(wQuo), .DIV_CYC(DIV_CYC)) u_div (
    .clk     (clk),
    .rst     (rst),
    .go      (div_go),
    .divisor (cfg_demontr),
    .done    (div_done),
    .quo     (div_quo),
    .rem     (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      desc     <= '0;
      dem      <= '0;
      m_num    <= '0;
      g_num    <= '0;
      factor   <= '0;
      inverse  <= 1'b0;
      step_q   <= '0;
      step_r   <= '0;
      acc_q    <= '0;
      acc_r    <= '0;
      k        <= '0;
      grp      <= '0;
      first    <= 1'b0;
      twdl_val <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      twdl_val <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start && cfg_good) begin
            dem     <= cfg_demontr;
            m_num   <= cfg_num_per_grp;
            g_num   <= cfg_num_grps;
            factor  <= cfg_factor;
            inverse <= cfg_inverse;
            acc_q   <= '0;
            acc_r   <= '0;
            k       <= '0;
            grp     <= '0;
            first   <= 1'b1;
            st      <= ST_DIV;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            step_q <= div_quo;
            step_r <= div_rem;
            st     <= ST_RUN;
          end
        end
        ST_RUN: begin
          twdl_val <= bfly_req;
          if (bfly_req) begin
            desc  <= '{sop: first, numrtr: k, demontr: dem, quotient: acc_q, remainder: acc_r};
            first <= 1'b0;
            if (wrap) begin
              k     <= '0;
              acc_q <= '0;
              acc_r <= '0;
              grp   <= grp + wNum'(1);
              if (grp_last) begin
                done <= 1'b1;
                st   <= ST_IDLE;
              end
            end else begin
              k <= k + wNum'(1);
              // r carries the fractional part of k*2^wQuo/D; overflow past D bumps q.
              if (r_sum >= {1'b0, dem}) begin
                acc_r <= wNum'(r_sum - {1'b0, dem});
                acc_q <= acc_q + step_q + wQuo'(1);
              end else begin
                acc_r <= r_sum[wNum-1:0];
                acc_q <= acc_q + step_q;
              end
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef TWDL_SEQ_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (div_go)
      drop_cnt <= '0;
    else if (bfly_req && !ready && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  assign twdl_sop       = desc.sop;
  assign twdl_numrtr    = desc.numrtr;
  assign twdl_demontr   = desc.demontr;
  assign twdl_quotient  = desc.quotient;
  assign twdl_remainder = desc.remainder;

endmodule

// File: tb/tb_twdl_seq_ctrl.sv
// Scoreboard bench for twdl_seq_ctrl; expected descriptors come from k*2^20 div/mod D.
`timescale 1ns/1ps
module tb_twdl_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_factor = '0;
  logic [11:0] cfg_demontr = '0, cfg_num_per_grp = '0, cfg_num_grps = '0;
  logic        cfg_inverse = 1'b0;
  logic        bfly_req = 1'b0;
  logic        ready, busy, cfg_err, done, twdl_val, twdl_sop, inverse;
  logic [11:0] twdl_numrtr, twdl_demontr, twdl_remainder;
  logic [19:0] twdl_quotient;
  logic [2:0]  factor;
`ifdef TWDL_SEQ_STAT_EN
  logic [15:0] drop_cnt;
`endif

  twdl_seq_ctrl #(.wNum(12), .wQuo(20), .DIV_CYC(21)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_factor(cfg_factor),
    .cfg_demontr(cfg_demontr), .cfg_num_per_grp(cfg_num_per_grp),
    .cfg_num_grps(cfg_num_grps), .cfg_inverse(cfg_inverse), .bfly_req(bfly_req),
    .ready(ready), .busy(busy), .cfg_err(cfg_err), .done(done), .twdl_val(twdl_val),
    .twdl_sop(twdl_sop), .twdl_numrtr(twdl_numrtr), .twdl_demontr(twdl_demontr),
    .twdl_quotient(twdl_quotient), .twdl_remainder(twdl_remainder),
`ifdef TWDL_SEQ_STAT_EN
    .drop_cnt(drop_cnt),
`endif
    .factor(factor), .inverse(inverse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit  sop;
    int  k;
    longint q;
    longint r;
    int  d;
    bit  last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;
  int   exp_drops = 0;
  int   cur_fac = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {twdl_val, done, ready, busy, cfg_err, twdl_sop, factor, inverse}, 0);
    chk({name, "_desc"}, {twdl_numrtr, twdl_demontr, twdl_remainder}, 0);
    chk({name, "_quo"}, twdl_quotient, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (twdl_val) begin
        if (sb.size() == 0) begin
          chk("unexpected_twdl_val", twdl_val, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sop", twdl_sop, mon_e.sop);
          chk("numrtr", twdl_numrtr, mon_e.k);
          chk("demontr", twdl_demontr, mon_e.d);
          chk("quotient", twdl_quotient, mon_e.q);
          chk("remainder", twdl_remainder, mon_e.r);
          chk("done_with_val", done, mon_e.last);
        end
      end else if (done) begin
        chk("done_without_val", done, 0);
      end
    end
  end

  task automatic drive_cfg(input int d, input int fac, input int m, input int g, input int inv);
    cfg_demontr     = 12'(d);
    cfg_factor      = 3'(fac);
    cfg_num_per_grp = 12'(m);
    cfg_num_grps    = 12'(g);
    cfg_inverse     = inv[0];
  endtask

  task automatic bad_start(input int d, input int fac, input int m, input int g);
    drive_cfg(d, fac, m, g, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("busy_after_bad", busy, 0);
    chk("factor_kept", factor, cur_fac);
    tick();
    chk("cfg_err_clear", cfg_err, 0);
    chk("busy_after_bad2", busy, 0);
  endtask

  // mode: 0 = request every cycle, 1 = alternate cycles, 2 = random
  task automatic run_stage(input int d, input int fac, input int m, input int g, input int inv,
                           input int mode, input int n_div_req, input int spur_at,
                           input int reset_at);
    int  total, beat, cyc;
    bit  req, spur_done;
    exp_t e;
    total = m * g;
    beat = 0;
    cyc = 0;
    spur_done = 0;
    drive_cfg(d, fac, m, g, inv);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_drops = 0;
    cur_fac = fac;
    chk("factor_latch", factor, fac);
    chk("inverse_latch", inverse, inv);
    chk("busy_div", busy, 1);
    for (int c = 0; c < 21; c++) begin
      chk("ready_div", ready, 0);
      bfly_req = (c < n_div_req);
      if (bfly_req) exp_drops++;
      tick();
    end
    bfly_req = 1'b0;
    chk("ready_run", ready, 1);
    chk("busy_run", busy, 1);
`ifdef TWDL_SEQ_STAT_EN
    chk("drop_cnt", drop_cnt, exp_drops);
`endif
    while (beat < total && cyc < 4000) begin
      if (beat == reset_at) begin
        bfly_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("reset_mid_run");
        sb.delete();
        tick();
        rst = 1'b0;
        cur_fac = 0;
        return;
      end
      case (mode)
        0:       req = 1'b1;
        1:       req = (cyc % 2 == 0);
        default: req = 1'($urandom_range(0, 1));
      endcase
      if (req) begin
        e.k    = beat % m;
        e.sop  = (beat == 0);
        e.q    = (longint'(e.k) << 20) / d;
        e.r    = (longint'(e.k) << 20) % d;
        e.d    = d;
        e.last = (beat == total - 1);
        sb.push_back(e);
      end
      bfly_req = req;
      if (!spur_done && beat == spur_at) begin
        spur_done = 1;
        drive_cfg(7, 2, 3, 1, inv ^ 1);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (req) beat++;
      cyc++;
    end
    bfly_req = 1'b0;
    chk("ready_after_last", ready, 0);
    chk("busy_after_last", busy, 0);
    chk("factor_held", factor, fac);
    chk("inverse_held", inverse, inv);
    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #20;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    run_stage(12, 3, 4, 2, 0, 0, 7, -1, -1);

    bad_start(1, 3, 4, 2);
    bad_start(12, 6, 4, 2);
    bad_start(5, 2, 6, 1);
    bad_start(12, 4, 0, 2);
    bad_start(12, 4, 4, 0);

    run_stage(5, 2, 5, 1, 1, 1, 0, -1, -1);
    run_stage(12, 4, 4, 2, 0, 0, 0, 3, -1);
    run_stage(100, 5, 6, 2, 1, 0, 0, -1, 3);
    run_stage(100, 5, 6, 2, 1, 0, 0, -1, -1);

    for (int i = 0; i < 6; i++) begin
      int d, m;
      d = int'($urandom_range(2, 4095));
      m = int'($urandom_range(1, (d < 12) ? d : 12));
      run_stage(d, int'($urandom_range(2, 5)), m, int'($urandom_range(1, 3)),
                int'($urandom_range(0, 1)), 2, int'($urandom_range(0, 5)), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with errors=%0d", errs);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/twdl_seq_ctrl.md
Name: twdl_seq_ctrl

Overview:
Per-stage sequencer for the twiddle multiplier of the mixed-radix (2/3/4/5) FFT/IFFT datapath. On each stage start it latches the stage configuration (radix, denominator, group geometry, direction) and precomputes the 2^20/D step with a sequential divider. For every butterfly request it then emits one twiddle descriptor: numerator, denominator, quotient and remainder. The descriptor fields are twdl_sop, twdl_numrtr, twdl_demontr, twdl_quotient and twdl_remainder, and the block drives the twiddle multiplier's matching inputs. It also latches factor and inverse for the twiddle multiplier.

Parameters:
wNum, 12, numerator/denominator width
wQuo, 20, quotient width; phase scale is 2^wQuo
DIV_CYC, 21, divider iterations (wQuo+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latch cfg_* and begin a stage
cfg_factor  in  3  radix: 2, 3, 4 or 5
cfg_demontr  in  12  twiddle denominator D
cfg_num_per_grp  in  12  numerators per group, M (k runs 0..M-1)
cfg_num_grps  in  12  group repetitions, G
cfg_inverse  in  1  0=FFT, 1=IFFT
bfly_req  in  1  one butterfly needs a twiddle this cycle
ready  out  1  accepting bfly_req
busy  out  1  stage in progress (DIV or RUN)
cfg_err  out  1  one-cycle pulse on rejected start
done  out  1  one-cycle pulse after last descriptor
twdl_val  out  1  descriptor valid
twdl_sop  out  1  first descriptor of stage
twdl_numrtr  out  12  k
twdl_demontr  out  12  D
twdl_quotient  out  20  floor(k*2^20/D)
twdl_remainder  out  12  (k*2^20) mod D
factor  out  3  latched radix
inverse  out  1  latched direction

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all counters 0. Reset mid-stage aborts immediately, with no done pulse.
- FSM states: IDLE, DIV, RUN.
- IDLE + start with D<2, M=0, G=0, M>D, or factor not in {2,3,4,5}:
  - cfg_err pulses next cycle.
  - FSM stays IDLE; latched config is unchanged.
- IDLE + valid start:
  - Latch the config; factor and inverse outputs update the next cycle.
  - Go to DIV and run a restoring divide of 2^20 by D for exactly DIV_CYC cycles, producing step_q (20b) and step_r (12b).
  - After the divide go to RUN. busy=1 throughout DIV and RUN.
- ready=1 only in RUN. bfly_req while ready=0 is dropped.
- start while busy=1 is ignored.
- RUN, per accepted bfly_req: outputs register one cycle later, with twdl_val=1.
  - Accumulator update after each accepted beat:
    - k<M-1: k+=1; r'=r+step_r; if r'>=D then r=r'-D and q=q+step_q+1, else r=r' and q=q+step_q. The compare uses 13-bit width.
    - k=M-1 (wrap): k=q=r=0 and grp+=1.
  - twdl_sop=1 on the first beat of the stage only.
- Last beat (k=M-1, grp=G-1):
  - twdl_val is high in the cycle that follows.
  - done pulses in that same cycle; FSM returns to IDLE.
  - ready drops in the cycle after the last accepted bfly_req.
- Outputs hold their values when twdl_val=0.
- No throughput bubbles: bfly_req may be high every RUN cycle.

Optional Feature:
TWDL_SEQ_STAT_EN
- Defined: add output drop_cnt[15:0], saturating. It counts bfly_req while ready=0, and clears on a valid start and on reset.
- Undefined: no port, no logic. Dropped requests are silently ignored.

Decomposition:
- Package twdl_seq_pkg: typedef enum for the FSM state, FACTOR_MIN=2, FACTOR_MAX=5, wQuo/wNum constants, and a descriptor struct {sop, numrtr, demontr, quotient, remainder}.
- Sub-module seq_div_u20: restoring unsigned divider.
  - Ports: clk, rst, go, divisor[11:0], done, quo[19:0], rem[11:0]. The dividend 2^20 is fixed internally.
  - Fixed latency DIV_CYC from go to done.

Test Plan:
- Divide and accumulate: start with D=12, factor=3, M=4, G=2, then bfly_req every cycle.
  - ready rises 21 cycles after start, and step_q=87381, step_r=4.
  - Descriptors (k,q,r): (0,0,0) (1,87381,4) (2,174762,8) (3,262144,0), then the same four again. sop only on the first; done with the 8th twdl_val.
- Invalid config: start with D=1, then separately with factor=6 -> cfg_err pulse, busy stays 0, no twdl_val.
- Gapped requests: D=5, M=5, G=1, bfly_req toggling 1010…
  - twdl_val mirrors each request one cycle later, with q sequence 0, 209715, 419430, 629145, 838860.
  - r sequence 0, 1, 2, 3, 4.
- Start while busy: a second start in mid-RUN is ignored; the sequence continues unchanged and done fires once.
- Async reset mid-RUN: assert rst at beat 3 -> all outputs 0 immediately; a fresh start after reset restarts at k=0.
- With TWDL_SEQ_STAT_EN: 7 bfly_req during DIV -> drop_cnt=7, and no descriptor is emitted for them.
